ttc_cfg_sequencer13: RTL and testbench
======================================

Name: ttc_cfg_sequencer13

Overview:
- Shares one ttc_timer_counter_lite13 register-write port between two requesters (e.g. power-manager and SW-mailbox agents).
- Round-robin arbitration picks a requester, then the block programs prescaler, interval, match-1 and interrupt enable, and starts the counter.
- It then waits for the timer interrupt, clears it, stops the counter, and returns done plus status to the owner.
- Sits between the requesters and the timer's select strobes, replacing direct APB writes.

Parameters:
- CTRL_RUN, 7'h12, cntr_ctrl word written to start: bit4 restart, bit1 interval mode, bit0=0 enabled.
- CTRL_STOP, 7'h01, cntr_ctrl word written to stop: bit0 disable.
- INTR_EN, 6'h03, interrupt-enable word (interval + match-1).
- TMO_W, 16, timeout counter width.

Ports:
- pclk13  in  1  system clock.
- n_p_reset13  in  1  asynchronous active-low reset.
- req13  in  2  per-requester level request; held until done13 or abandoned.
- cfg_clk13  in  14  {req1[6:0], req0[6:0]} clk_ctrl values.
- cfg_interval13  in  32  {req1, req0} 16-bit interval values.
- cfg_match13  in  32  {req1, req0} 16-bit match-1 values.
- tmo_limit13  in  TMO_W  cycles to wait for interrupt; 0 = no timeout.
- grant13  out  2  one-hot owner, held from grant to done.
- done13  out  2  one-cycle completion pulse to owner.
- err13  out  1  valid with done13: 1 = timeout.
- irq_status13  out  6  interrupt_reg13 snapshot, valid with done13.
- busy13  out  1  state != IDLE.
- pwdata13  out  16  write data to timer.
- clk_ctrl_reg_sel13, interval_reg_sel13, match_1_reg_sel13, intr_en_reg_sel13, cntr_ctrl_reg_sel13  out  1 each  timer write strobes.
- clear_interrupt13  out  1  timer interrupt clear.
- interrupt13  in  1  timer interrupt.
- interrupt_reg13  in  6  timer interrupt status.

Behaviour:
- Clock and reset: one clock, pclk13. Reset n_p_reset13 is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, last-grant pointer = 1, so req0 wins the first tie.
- Outputs are registered; at most one strobe is high per cycle, and pwdata13 is valid in the same cycle as its strobe.
- pwdata13 = 0 when no strobe is high; upper bits are zero-extended for 7-bit and 6-bit words.
- States: IDLE, W_CLK, W_INTV, W_MATCH, W_IEN, W_CTRL, WAIT, CLR, STOP, DONE.
- IDLE: any req13 bit at edge k -> grant registered at k+1 and state W_CLK.
- Arbitration on a tie: grant the requester not granted last. Arbitration happens only in IDLE.
- W_CLK..W_CTRL: one cycle each, emitting clk_ctrl_reg_sel13 (cfg_clk), interval_reg_sel13, match_1_reg_sel13, intr_en_reg_sel13 (INTR_EN), then cntr_ctrl_reg_sel13 (CTRL_RUN), using the owner's config slice.
- First strobe is at k+1; CTRL_RUN is at k+5.
- Config is sampled in the cycle each strobe is driven; requesters must hold config stable while granted.
- WAIT:
  - Timeout counter starts at 0 and increments each cycle.
  - interrupt13=1 -> capture interrupt_reg13 into an internal register, err=0, go to CLR.
  - tmo_limit13!=0 and count==tmo_limit13-1 -> err=1, capture interrupt_reg13, go to CLR.
  - Interrupt wins over timeout in the same cycle.
- CLR: clear_interrupt13=1 for one cycle.
- STOP: cntr_ctrl_reg_sel13=1 with pwdata13=CTRL_STOP for one cycle.
- DONE: done13[owner]=1 for one cycle, with err13 and irq_status13 driven; grant cleared and pointer updated next cycle; back to IDLE.
- Abandon: owner's req13 deasserted in any state from W_CLK to WAIT -> go to CLR, then STOP, then IDLE.
  - No done13 pulse on abandon; grant is cleared on IDLE entry.
  - Abandon during CLR/STOP/DONE is ignored; the sequence completes normally.
- Non-owner requests are ignored while busy and stay pending; the next IDLE arbitration grants them.
- Reset mid-sequence: outputs drop to 0 immediately. The timer's own reset is expected to come from the same n_p_reset13.
- Timeout counter saturates at all-ones.

Test Plan:
- req13=01, cfg_clk=7'h03, interval=16'h0010, match=16'h0008; interrupt at cycle k+20:
  - Strobes at k+1..k+5 with pwdata 0003, 0010, 0008, 0003, 0012.
  - clear at k+21, STOP (0001) at k+22, done13=01 at k+23, err13=0.
- req13=11 raised together from reset: grant13=01 first; after its done, grant13=10 without req1 re-arbitration delay beyond one IDLE cycle.
- tmo_limit13=5, interrupt never asserted: timeout fires 5 cycles after WAIT entry; done13 with err13=1, irq_status13 = current interrupt_reg13.
- Drop req0 during W_MATCH: clear then STOP strobe, no done13 pulse, grant13 returns to 0, busy13 falls.
- Assert n_p_reset13=0 while in WAIT: all strobes/grant/busy go to 0 asynchronously; after release, new req13=10 gets full sequence.
- interrupt13 and timeout in the same cycle: err13=0.

Source files
------------

// File: rtl/ttc_cfg_sequencer13.sv
// Arbitrates two requesters onto a single timer register-write port and runs the
// program / start / wait-for-irq / clear / stop sequence on behalf of the owner.
module ttc_cfg_sequencer13 #(
    parameter logic [6:0] CTRL_RUN  = 7'h12,
    parameter logic [6:0] CTRL_STOP = 7'h01,
    parameter logic [5:0] INTR_EN   = 6'h03,
    parameter int         TMO_W     = 16
) (
    input  logic             pclk13,
    input  logic             n_p_reset13,
    input  logic [1:0]       req13,
    input  logic [13:0]      cfg_clk13,
    input  logic [31:0]      cfg_interval13,
    input  logic [31:0]      cfg_match13,
    input  logic [TMO_W-1:0] tmo_limit13,
    output logic [1:0]       grant13,
    output logic [1:0]       done13,
    output logic             err13,
    output logic [5:0]       irq_status13,
    output logic             busy13,
    output logic [15:0]      pwdata13,
    output logic             clk_ctrl_reg_sel13,
    output logic             interval_reg_sel13,
    output logic             match_1_reg_sel13,
    output logic             intr_en_reg_sel13,
    output logic             cntr_ctrl_reg_sel13,
    output logic             clear_interrupt13,
    input  logic             interrupt13,
    input  logic [5:0]       interrupt_reg13
);

    typedef enum logic [3:0] {
        IDLE, W_CLK, W_INTV, W_MATCH, W_IEN, W_CTRL, WAIT, CLR, STOP, DONE
    } state_t;

    state_t           state, state_nxt;
    logic             owner, owner_nxt;
    logic             last_grant;
    logic             abandon, abandon_nxt;
    logic             err_cap, err_nxt;
    logic [5:0]       irq_cap, irq_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             winner;
    logic             owner_req;
    logic             tmo_hit;
    logic [1:0]       owner_hot_nxt;
    logic [15:0]      pwdata_nxt;

    // A tie goes to whichever requester did not own the port last time.
    always_comb begin
        winner = 1'b0;
        if (req13 == 2'b11) begin
            winner = ~last_grant;
        end else if (req13[1] && !req13[0]) begin
            winner = 1'b1;
        end
    end

    assign owner_req     = owner ? req13[1] : req13[0];
    assign tmo_hit       = (tmo_limit13 != '0) && (tmo_cnt == tmo_limit13 - TMO_W'(1));
    assign owner_hot_nxt = owner_nxt ? 2'b10 : 2'b01;

    always_ff @(posedge pclk13 or negedge n_p_reset13) begin
        if (!n_p_reset13) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            abandon    <= 1'b0;
            err_cap    <= 1'b0;
            irq_cap    <= '0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            abandon <= abandon_nxt;
            err_cap <= err_nxt;
            irq_cap <= irq_nxt;
            if (state != IDLE && state_nxt == IDLE) begin
                last_grant <= owner;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        abandon_nxt = abandon;
        err_nxt     = err_cap;
        irq_nxt     = irq_cap;
        case (state)
            IDLE: begin
                if (|req13) begin
                    state_nxt   = W_CLK;
                    owner_nxt   = winner;
                    abandon_nxt = 1'b0;
                    err_nxt     = 1'b0;
                    irq_nxt     = '0;
                end
            end
            W_CLK:   state_nxt = W_INTV;
            W_INTV:  state_nxt = W_MATCH;
            W_MATCH: state_nxt = W_IEN;
            W_IEN:   state_nxt = W_CTRL;
            W_CTRL:  state_nxt = WAIT;
            WAIT: begin
                if (interrupt13) begin
                    state_nxt = CLR;
                    err_nxt   = 1'b0;
                    irq_nxt   = interrupt_reg13;
                end else if (tmo_hit) begin
                    state_nxt = CLR;
                    err_nxt   = 1'b1;
                    irq_nxt   = interrupt_reg13;
                end
            end
            CLR:     state_nxt = STOP;
            STOP:    state_nxt = abandon ? IDLE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Owner walking away mid-programming still gets the timer cleaned up.
        if ((state == W_CLK || state == W_INTV || state == W_MATCH || state == W_IEN ||
             state == W_CTRL || state == WAIT) && !owner_req) begin
            state_nxt   = CLR;
            abandon_nxt = 1'b1;
        end
    end

    always_comb begin
        pwdata_nxt = '0;
        case (state_nxt)
            W_CLK:   pwdata_nxt = {9'b0, (owner_nxt ? cfg_clk13[13:7] : cfg_clk13[6:0])};
            W_INTV:  pwdata_nxt = owner_nxt ? cfg_interval13[31:16] : cfg_interval13[15:0];
            W_MATCH: pwdata_nxt = owner_nxt ? cfg_match13[31:16] : cfg_match13[15:0];
            W_IEN:   pwdata_nxt = {10'b0, INTR_EN};
            W_CTRL:  pwdata_nxt = {9'b0, CTRL_RUN};
            STOP:    pwdata_nxt = {9'b0, CTRL_STOP};
            default: pwdata_nxt = '0;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge pclk13 or negedge n_p_reset13) begin
        if (!n_p_reset13) begin
            grant13             <= '0;
            done13              <= '0;
            err13               <= 1'b0;
            irq_status13        <= '0;
            busy13              <= 1'b0;
            pwdata13            <= '0;
            clk_ctrl_reg_sel13  <= 1'b0;
            interval_reg_sel13  <= 1'b0;
            match_1_reg_sel13   <= 1'b0;
            intr_en_reg_sel13   <= 1'b0;
            cntr_ctrl_reg_sel13 <= 1'b0;
            clear_interrupt13   <= 1'b0;
        end else begin
            grant13             <= (state_nxt == IDLE) ? 2'b00 : owner_hot_nxt;
            done13              <= (state_nxt == DONE) ? owner_hot_nxt : 2'b00;
            err13               <= (state_nxt == DONE) ? err_nxt : 1'b0;
            irq_status13        <= (state_nxt == DONE) ? irq_nxt : 6'h00;
            busy13              <= (state_nxt != IDLE);
            pwdata13            <= pwdata_nxt;
            clk_ctrl_reg_sel13  <= (state_nxt == W_CLK);
            interval_reg_sel13  <= (state_nxt == W_INTV);
            match_1_reg_sel13   <= (state_nxt == W_MATCH);
            intr_en_reg_sel13   <= (state_nxt == W_IEN);
            cntr_ctrl_reg_sel13 <= (state_nxt == W_CTRL) || (state_nxt == STOP);
            clear_interrupt13   <= (state_nxt == CLR);
        end
    end

    always_ff @(posedge pclk13 or negedge n_p_reset13) begin
        if (!n_p_reset13) begin
            tmo_cnt <= '0;
        end else if (state != WAIT) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

endmodule

// File: tb/tb_ttc_cfg_sequencer13.sv
// Directed bench for ttc_cfg_sequencer13: each task drives one scenario and checks
// cycle-exact outputs against hand-computed values.
module tb_ttc_cfg_sequencer13;

    logic        pclk13 = 1'b0;
    logic        n_p_reset13;
    logic [1:0]  req13;
    logic [13:0] cfg_clk13;
    logic [31:0] cfg_interval13;
    logic [31:0] cfg_match13;
    logic [15:0] tmo_limit13;
    logic [1:0]  grant13;
    logic [1:0]  done13;
    logic        err13;
    logic [5:0]  irq_status13;
    logic        busy13;
    logic [15:0] pwdata13;
    logic        clk_ctrl_reg_sel13, interval_reg_sel13, match_1_reg_sel13;
    logic        intr_en_reg_sel13, cntr_ctrl_reg_sel13, clear_interrupt13;
    logic        interrupt13;
    logic [5:0]  interrupt_reg13;

    logic [4:0]  sel;
    logic [33:0] outs;

    int vectors = 0;
    int miscompares = 0;

    ttc_cfg_sequencer13 dut (
        .pclk13              (pclk13),
        .n_p_reset13         (n_p_reset13),
        .req13               (req13),
        .cfg_clk13           (cfg_clk13),
        .cfg_interval13      (cfg_interval13),
        .cfg_match13         (cfg_match13),
        .tmo_limit13         (tmo_limit13),
        .grant13             (grant13),
        .done13              (done13),
        .err13               (err13),
        .irq_status13        (irq_status13),
        .busy13              (busy13),
        .pwdata13            (pwdata13),
        .clk_ctrl_reg_sel13  (clk_ctrl_reg_sel13),
        .interval_reg_sel13  (interval_reg_sel13),
        .match_1_reg_sel13   (match_1_reg_sel13),
        .intr_en_reg_sel13   (intr_en_reg_sel13),
        .cntr_ctrl_reg_sel13 (cntr_ctrl_reg_sel13),
        .clear_interrupt13   (clear_interrupt13),
        .interrupt13         (interrupt13),
        .interrupt_reg13     (interrupt_reg13)
    );

    always #5 pclk13 = ~pclk13;

    assign sel  = {clk_ctrl_reg_sel13, interval_reg_sel13, match_1_reg_sel13,
                   intr_en_reg_sel13, cntr_ctrl_reg_sel13};
    assign outs = {grant13, done13, err13, irq_status13, busy13, sel, clear_interrupt13, pwdata13};

    task automatic tick();
        @(posedge pclk13);
        #1;
    endtask

    task automatic test_reset();
        n_p_reset13 = 1'b0;
        req13 = 2'b00;
        interrupt13 = 1'b0;
        interrupt_reg13 = 6'h00;
        tmo_limit13 = 16'd0;
        #12;
        vectors++;
        if (outs !== 34'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h want=0", outs);
        end
        @(negedge pclk13);
        n_p_reset13 = 1'b1;
        tick();
        vectors++;
        if (outs !== 34'h0) begin
            miscompares++;
            $display("FAIL idle_no_req got=%h want=0", outs);
        end
    endtask

    task automatic test_tie_round_robin();
        req13 = 2'b11;
        tick();
        vectors++;
        if ({grant13, sel, pwdata13} !== {2'b01, 5'b10000, 16'h0003}) begin
            miscompares++;
            $display("FAIL tie_first_grant got=%b/%b/%h want=01/10000/0003", grant13, sel, pwdata13);
        end
        repeat (5) tick();
        interrupt13 = 1'b1;
        interrupt_reg13 = 6'h01;
        tick();
        vectors++;
        if (clear_interrupt13 !== 1'b1) begin
            miscompares++;
            $display("FAIL tie_clear0 got=%b want=1", clear_interrupt13);
        end
        interrupt13 = 1'b0;
        tick();
        tick();
        vectors++;
        if ({done13, err13} !== {2'b01, 1'b0}) begin
            miscompares++;
            $display("FAIL tie_done0 got=%b/%b want=01/0", done13, err13);
        end
        req13 = 2'b10;
        tick();
        vectors++;
        if ({grant13, busy13} !== 3'b000) begin
            miscompares++;
            $display("FAIL tie_idle_gap got=%b/%b want=00/0", grant13, busy13);
        end
        tick();
        vectors++;
        if ({grant13, sel, pwdata13} !== {2'b10, 5'b10000, 16'h0015}) begin
            miscompares++;
            $display("FAIL tie_second_grant got=%b/%b/%h want=10/10000/0015", grant13, sel, pwdata13);
        end
        repeat (4) tick();
        vectors++;
        if ({sel, pwdata13} !== {5'b00001, 16'h0012}) begin
            miscompares++;
            $display("FAIL tie_run1 got=%b/%h want=00001/0012", sel, pwdata13);
        end
        tick();
        interrupt13 = 1'b1;
        interrupt_reg13 = 6'h22;
        tick();
        interrupt13 = 1'b0;
        tick();
        vectors++;
        if ({sel, pwdata13} !== {5'b00001, 16'h0001}) begin
            miscompares++;
            $display("FAIL tie_stop1 got=%b/%h want=00001/0001", sel, pwdata13);
        end
        tick();
        vectors++;
        if ({done13, err13, irq_status13} !== {2'b10, 1'b0, 6'h22}) begin
            miscompares++;
            $display("FAIL tie_done1 got=%b/%b/%h want=10/0/22", done13, err13, irq_status13);
        end
        req13 = 2'b00;
        tick();
    endtask

    task automatic test_basic_sequence();
        logic [4:0]  exp_sel [5];
        logic [15:0] exp_dat [5];
        exp_sel = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
        exp_dat = '{16'h0003, 16'h0010, 16'h0008, 16'h0003, 16'h0012};
        req13 = 2'b01;
        for (int t = 0; t < 5; t++) begin
            tick();
            vectors++;
            if ({grant13, sel, pwdata13} !== {2'b01, exp_sel[t], exp_dat[t]}) begin
                miscompares++;
                $display("FAIL basic_strobe%0d got=%b/%b/%h want=01/%b/%h",
                         t + 1, grant13, sel, pwdata13, exp_sel[t], exp_dat[t]);
            end
        end
        for (int t = 6; t <= 20; t++) begin
            tick();
            vectors++;
            if ({busy13, sel, clear_interrupt13, pwdata13} !== {1'b1, 5'b0, 1'b0, 16'h0}) begin
                miscompares++;
                $display("FAIL basic_wait%0d got=%b/%b/%b/%h want=1/00000/0/0000",
                         t, busy13, sel, clear_interrupt13, pwdata13);
            end
        end
        interrupt13 = 1'b1;
        interrupt_reg13 = 6'h05;
        tick();
        vectors++;
        if ({clear_interrupt13, sel} !== {1'b1, 5'b0}) begin
            miscompares++;
            $display("FAIL basic_clear got=%b/%b want=1/00000", clear_interrupt13, sel);
        end
        interrupt13 = 1'b0;
        tick();
        vectors++;
        if ({clear_interrupt13, sel, pwdata13} !== {1'b0, 5'b00001, 16'h0001}) begin
            miscompares++;
            $display("FAIL basic_stop got=%b/%b/%h want=0/00001/0001", clear_interrupt13, sel, pwdata13);
        end
        tick();
        vectors++;
        if ({grant13, done13, err13, irq_status13} !== {2'b01, 2'b01, 1'b0, 6'h05}) begin
            miscompares++;
            $display("FAIL basic_done got=%b/%b/%b/%h want=01/01/0/05", grant13, done13, err13, irq_status13);
        end
        req13 = 2'b00;
        tick();
        vectors++;
        if ({grant13, done13, busy13} !== 5'b0) begin
            miscompares++;
            $display("FAIL basic_idle got=%b/%b/%b want=00/00/0", grant13, done13, busy13);
        end
    endtask

    task automatic test_timeout();
        tmo_limit13 = 16'd5;
        interrupt_reg13 = 6'h2A;
        req13 = 2'b01;
        repeat (10) tick();
        vectors++;
        if ({busy13, clear_interrupt13} !== 2'b10) begin
            miscompares++;
            $display("FAIL tmo_still_wait got=%b/%b want=1/0", busy13, clear_interrupt13);
        end
        tick();
        vectors++;
        if (clear_interrupt13 !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_clear got=%b want=1", clear_interrupt13);
        end
        tick();
        tick();
        vectors++;
        if ({done13, err13, irq_status13} !== {2'b01, 1'b1, 6'h2A}) begin
            miscompares++;
            $display("FAIL tmo_done got=%b/%b/%h want=01/1/2a", done13, err13, irq_status13);
        end
        req13 = 2'b00;
        tick();
    endtask

    task automatic test_irq_vs_timeout();
        tmo_limit13 = 16'd5;
        interrupt_reg13 = 6'h11;
        req13 = 2'b01;
        repeat (10) tick();
        interrupt13 = 1'b1;
        tick();
        vectors++;
        if (clear_interrupt13 !== 1'b1) begin
            miscompares++;
            $display("FAIL race_clear got=%b want=1", clear_interrupt13);
        end
        interrupt13 = 1'b0;
        tick();
        tick();
        vectors++;
        if ({done13, err13, irq_status13} !== {2'b01, 1'b0, 6'h11}) begin
            miscompares++;
            $display("FAIL race_done got=%b/%b/%h want=01/0/11", done13, err13, irq_status13);
        end
        req13 = 2'b00;
        tick();
        tmo_limit13 = 16'd0;
    endtask

    task automatic test_abandon();
        req13 = 2'b01;
        repeat (3) tick();
        vectors++;
        if ({grant13, sel} !== {2'b01, 5'b00100}) begin
            miscompares++;
            $display("FAIL abandon_match got=%b/%b want=01/00100", grant13, sel);
        end
        req13 = 2'b00;
        tick();
        vectors++;
        if ({clear_interrupt13, sel, done13} !== {1'b1, 5'b0, 2'b00}) begin
            miscompares++;
            $display("FAIL abandon_clear got=%b/%b/%b want=1/00000/00", clear_interrupt13, sel, done13);
        end
        tick();
        vectors++;
        if ({sel, pwdata13, done13} !== {5'b00001, 16'h0001, 2'b00}) begin
            miscompares++;
            $display("FAIL abandon_stop got=%b/%h/%b want=00001/0001/00", sel, pwdata13, done13);
        end
        tick();
        vectors++;
        if ({grant13, busy13, done13} !== 5'b0) begin
            miscompares++;
            $display("FAIL abandon_idle got=%b/%b/%b want=00/0/00", grant13, busy13, done13);
        end
        tick();
        vectors++;
        if (done13 !== 2'b00) begin
            miscompares++;
            $display("FAIL abandon_no_done got=%b want=00", done13);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [4:0]  exp_sel [5];
        logic [15:0] exp_dat [5];
        exp_sel = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
        exp_dat = '{16'h0015, 16'h1234, 16'h0ABC, 16'h0003, 16'h0012};
        req13 = 2'b10;
        repeat (6) tick();
        vectors++;
        if ({grant13, busy13} !== 3'b101) begin
            miscompares++;
            $display("FAIL rst_in_wait got=%b/%b want=10/1", grant13, busy13);
        end
        #2;
        n_p_reset13 = 1'b0;
        #1;
        vectors++;
        if (outs !== 34'h0) begin
            miscompares++;
            $display("FAIL rst_async got=%h want=0", outs);
        end
        req13 = 2'b00;
        @(negedge pclk13);
        n_p_reset13 = 1'b1;
        req13 = 2'b10;
        for (int t = 0; t < 5; t++) begin
            tick();
            vectors++;
            if ({grant13, sel, pwdata13} !== {2'b10, exp_sel[t], exp_dat[t]}) begin
                miscompares++;
                $display("FAIL rst_seq%0d got=%b/%b/%h want=10/%b/%h",
                         t + 1, grant13, sel, pwdata13, exp_sel[t], exp_dat[t]);
            end
        end
        tick();
        interrupt13 = 1'b1;
        interrupt_reg13 = 6'h03;
        tick();
        interrupt13 = 1'b0;
        tick();
        tick();
        vectors++;
        if ({done13, err13, irq_status13} !== {2'b10, 1'b0, 6'h03}) begin
            miscompares++;
            $display("FAIL rst_done got=%b/%b/%h want=10/0/03", done13, err13, irq_status13);
        end
        req13 = 2'b00;
        tick();
    endtask

    initial begin
        cfg_clk13      = {7'h15, 7'h03};
        cfg_interval13 = {16'h1234, 16'h0010};
        cfg_match13    = {16'h0ABC, 16'h0008};
        test_reset();
        test_tie_round_robin();
        test_basic_sequence();
        test_timeout();
        test_irq_vs_timeout();
        test_abandon();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
